sample_reader: RTL
==================

Name: sample_reader

Overview:
Read-side controller for the 4096 x 18-bit capture buffer. On a start request it computes the pre-trigger start address and walks the read port sequentially, wrapping modulo 4096. It absorbs the one-cycle RAM read latency and streams samples to the MCU interface over a valid/ready handshake. It sits between the capture RAM read port and the MCU bus bridge.

Parameters:
ADDR_W, 12, RAM address width; depth = 2**ADDR_W.
DATA_W, 18, sample width (16 data bits + 2 flag bits).

Ports:
Clk  input  1  single system clock, rising edge.
Rst  input  1  synchronous active-high reset.
Start  input  1  one-cycle request; sampled only in IDLE.
Trig_addr  input  ADDR_W  RAM address of the trigger sample.
Pre_depth  input  ADDR_W  number of samples before the trigger to include.
Length  input  ADDR_W+1  samples to stream; 0 = none; values above 4096 are clamped to 4096.
Raddr  output  ADDR_W  RAM read address.
Rdata  input  DATA_W  RAM read data, valid one Clk cycle after Raddr.
Dout  output  DATA_W  streamed sample.
Dvalid  output  1  Dout holds a valid sample.
Dready  input  1  consumer accepts; a beat transfers when Dvalid & Dready.
Busy  output  1  transfer in progress.
Done  output  1  one-cycle pulse when the transfer ends.

Behaviour:
- Reset values: Raddr=0, Dout=0, Dvalid=0, Busy=0, Done=0, state=IDLE, skid empty, counters 0.
- Rst is honoured in any state. The next cycle shows reset values; there is no residual Done and no in-flight data.
- States:
  - IDLE: on Start, go to STREAM with Busy=1 and Raddr = (Trig_addr - Pre_depth) mod 4096. Load issue_cnt and beat_cnt with the clamped Length. If Length==0, go to FIN instead.
  - STREAM: issue one read per cycle while issue_cnt>0 and (skid_count + inflight) < 2. Each issued read increments Raddr mod 4096 and decrements issue_cnt. Each accepted beat decrements beat_cnt. When the last beat is accepted, go to FIN.
  - FIN: Done=1 for exactly one cycle, Busy=0, then return to IDLE.
- Start is ignored while Busy=1 or in FIN.
- Raddr holds its value when no read is issued. Reads are never speculative beyond 2 outstanding entries.
- Latency with Dready held at 1:
  - Start sampled at edge 0.
  - Raddr = start address after edge 0.
  - Dout = M[start], Dvalid = 1 after edge 2.
  - Sustained throughput is 1 sample/cycle.
  - Done asserts the cycle after the last handshake.
- Backpressure: while Dvalid & !Dready, Dout and Dvalid hold stable. No sample is lost or duplicated, and read order is preserved.
- Wrap-around: the address after 4095 is 0. The start-address subtraction wraps the same way (Trig_addr=5, Pre_depth=10 -> 4091).
- Length clamp: requests above 4096 stream exactly 4096 samples. Each address is read once, even though Raddr returns to its start value.
- Simultaneous events: when a last-beat handshake and a new read return land in the same cycle, the skid pushes and pops in that cycle. A Start arriving in the same cycle as Done is ignored.

Decomposition:
- Shared package holds ADDR_W=12, DATA_W=18, DEPTH=4096, the state encoding (IDLE, STREAM, FIN) and the length-clamp constant.
- One sub-module: rd_skid_fifo, a 2-entry registered FIFO with push/pop/count. It holds returning Rdata and drives Dout/Dvalid.

Test Plan:
- Basic: Trig_addr=100, Pre_depth=20, Length=8, Dready=1 -> Raddr 80..87 on consecutive cycles; Dout=M[80]..M[87] back-to-back from edge 2; single Done pulse; Busy low afterward.
- Wrap: Trig_addr=5, Pre_depth=10, Length=10 -> addresses 4091..4095 then 0..4, data in that order, 10 beats exactly.
- Backpressure: Length=16, Dready pattern 1,0,0,1,0,1,1,0 repeating -> 16 unique in-order beats; Dout stable during every stall; outstanding reads never exceed 2.
- Boundaries: Length=0 -> Done one cycle after Start, Dvalid never asserts. Length=5000 -> exactly 4096 beats, then Done.
- Control: Start pulsed mid-transfer -> ignored, beat count unchanged. Rst asserted at beat 3 of 8 -> next cycle Dvalid=0, Busy=0, Done=0. A new Start then completes normally.

Source files
------------

// File: rtl/sample_reader_pkg.sv
// Shared widths, FSM encoding and length-clamp constant for the capture-buffer
// read controller.
package sample_reader_pkg;

    localparam int SR_ADDR_W = 12;
    localparam int SR_DATA_W = 18;
    localparam int SR_DEPTH  = 1 << SR_ADDR_W;

    // Largest transfer: one full pass over the buffer.
    localparam logic [SR_ADDR_W:0] SR_LEN_MAX = (SR_ADDR_W + 1)'(SR_DEPTH);

    typedef logic [1:0] sr_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FIN    = 2'd2;

endpackage

// File: rtl/sample_reader_rd_skid_fifo.sv
// Two-entry registered FIFO that catches RAM read data and presents the head
// entry as the streamed sample.
module rd_skid_fifo #(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The head only moves on a pop, so it stays put while the consumer stalls.
    assign dout   = mem_q[rd_ptr_q];
    assign dvalid = (count_q != 2'd0);
    assign count  = count_q;

endmodule

// File: rtl/sample_reader.sv
// Read-side controller: walks the capture RAM from the pre-trigger address,
// absorbs the one-cycle read latency and streams samples out.
module sample_reader
    import sample_reader_pkg::*;
#(
    parameter int ADDR_W = SR_ADDR_W,
    parameter int DATA_W = SR_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Trig_addr,
    input  logic [ADDR_W-1:0] Pre_depth,
    input  logic [ADDR_W:0]   Length,
    output logic [ADDR_W-1:0] Raddr,
    input  logic [DATA_W-1:0] Rdata,
    output logic [DATA_W-1:0] Dout,
    output logic              Dvalid,
    input  logic              Dready,
    output logic              Busy,
    output logic              Done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    sr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              inflight_q, inflight_d;

    logic [CNT_W-1:0]  len_clamped;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;

    // Handshake: a beat transfers on a rising edge where Dvalid and Dready are
    // both high; Dvalid never drops and Dout never changes until that happens.
    assign pop = Dvalid && Dready;

    always_comb begin
        len_clamped = (Length > LEN_MAX) ? LEN_MAX : Length;
        // Credit the slot freed by this cycle's pop so a full pipe still
        // sustains one read per cycle without exceeding two outstanding entries.
        occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == ST_STREAM) && (issue_cnt_q != '0) && (occupancy < 3'd2);

        state_d     = state_q;
        raddr_d     = raddr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    raddr_d     = Trig_addr - Pre_depth;
                    issue_cnt_d = len_clamped;
                    beat_cnt_d  = len_clamped;
                    state_d     = (len_clamped == '0) ? ST_FIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    raddr_d     = raddr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q - CNT_W'(1);
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q - CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            raddr_q     <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (Clk),
        .rst       (Rst),
        .push      (inflight_q),
        .push_data (Rdata),
        .pop       (pop),
        .dout      (Dout),
        .dvalid    (Dvalid),
        .count     (fifo_count)
    );

    assign Raddr = raddr_q;
    assign Busy  = (state_q == ST_STREAM);
    assign Done  = (state_q == ST_FIN);

endmodule
